// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: pipeline register between CPU stages with a valid/ready
// handshake, synchronous flush and an optional 2-entry skid buffer.
//
// Handshake: a transfer happens on a rising clk edge exactly when valid and
// ready are both high in that cycle (in_fire on the upstream side, out_fire on
// the downstream side). A producer raising valid keeps valid and data stable
// until the transfer. Ready may be high or low independently of valid. out_valid
// and out_data stay stable until out_fire.
//
// The state encoding equals the number of held entries, so the occupancy port
// is the state register itself and doubles as the FSM debug view.
module pipe_stage_hs #(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    parameter bit                SKID      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // Encoding chosen so that state value == entries held.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             in_fire;
    logic             out_fire;

    // Outputs decoded from registered state only.
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;

    // With the skid entry, ready depends on the state register alone and
    // breaks the combinational ready chain; without it, a full stage can still
    // accept when the downstream drains it in the same cycle.
    generate
        if (SKID) begin : g_ready_reg
            assign in_ready = (state_q != FULL);
        end else begin : g_ready_comb
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Next-state and data-path selection; flush overrides every handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // A flushed in_fire is dropped; an out_fire this cycle was already
            // taken by the downstream stage, so nothing else to undo.
            state_d = EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end else if (in_fire) begin
                        // Only reachable with the skid entry: the combinational
                        // ready of the 1-entry variant forbids accepting while
                        // holding an entry that is not leaving.
                        if (SKID) begin
                            state_d = FULL;
                            skid_d  = in_data;
                        end
                    end else if (out_fire) begin
                        // main_q keeps the last delivered value on drain.
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = RESET_VAL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = RESET_VAL;
                    skid_d  = RESET_VAL;
                end
            endcase
        end
    end

    // State and data registers; reset drops all entries immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: one instance with the 1-entry variant (index 0)
// and one with the skid buffer (index 1). A FIFO model per instance predicts
// every output each cycle; directed sequences pin the model with literals.
module tb_pipe_stage_hs;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       flush     [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] in_data   [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] out_data  [2];
    logic [1:0] occupancy [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Model: entries held in arrival order, plus last value shown on out_data.
    int         m_cnt  [2];
    logic [7:0] m_ent  [2][2];
    logic [7:0] m_last [2];

    always #5 clk = ~clk;

    pipe_stage_hs #(.WIDTH(8), .RESET_VAL(8'h00), .SKID(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .occupancy(occupancy[0])
    );

    pipe_stage_hs #(.WIDTH(8), .RESET_VAL(8'h00), .SKID(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .occupancy(occupancy[1])
    );

    function automatic logic m_in_ready(input int k);
        if (k == 1) return (m_cnt[k] < 2);
        return (m_cnt[k] == 0) || out_ready[k];
    endfunction

    function automatic logic [7:0] m_out_data(input int k);
        return (m_cnt[k] > 0) ? m_ent[k][0] : m_last[k];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear(input int k);
        m_cnt[k]    = 0;
        m_last[k]   = 8'h00;
        m_ent[k][0] = 8'h00;
        m_ent[k][1] = 8'h00;
    endtask

    task automatic model_update(input int k);
        logic ifire;
        logic ofire;
        if (flush[k]) begin
            model_clear(k);
        end else begin
            ifire = in_valid[k] && m_in_ready(k);
            ofire = (m_cnt[k] > 0) && out_ready[k];
            if (ofire) begin
                m_last[k]   = m_ent[k][0];
                m_ent[k][0] = m_ent[k][1];
                m_cnt[k]    = m_cnt[k] - 1;
            end
            if (ifire) begin
                m_ent[k][m_cnt[k]] = in_data[k];
                m_cnt[k]           = m_cnt[k] + 1;
            end
        end
    endtask

    initial begin
        logic fired [2];
        logic [7:0] d;
        logic exp_rdy;
        for (int k = 0; k < 2; k++) begin
            flush[k] = 1'b0; in_valid[k] = 1'b0; in_data[k] = 8'h00; out_ready[k] = 1'b0;
            model_clear(k);
        end

        fork
            // Model advances on each clock edge; reset empties it at once.
            forever begin
                @(posedge clk or posedge reset);
                for (int k = 0; k < 2; k++) begin
                    if (reset) model_clear(k);
                    else       model_update(k);
                end
            end
            // Every cycle, away from the active edge, compare all outputs.
            forever begin
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("dut%0d_out_valid", k), 32'(out_valid[k]), 32'(m_cnt[k] > 0));
                    check($sformatf("dut%0d_occupancy", k), 32'(occupancy[k]), 32'(m_cnt[k]));
                    check($sformatf("dut%0d_in_ready", k), 32'(in_ready[k]), 32'(m_in_ready(k)));
                    check($sformatf("dut%0d_out_data", k), 32'(out_data[k]), 32'(m_out_data(k)));
                end
            end
        join_none

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid[1]), 32'd0);
        check("rst_occupancy", 32'(occupancy[1]), 32'd0);
        check("rst_in_ready", 32'(in_ready[1]), 32'd1);
        check("rst_out_data", 32'(out_data[1]), 32'h00);
        reset = 1'b0;

        // Test 1: streaming at full rate
        out_ready[1] = 1'b1;
        in_valid[1]  = 1'b1;
        in_data[1]   = 8'h11;
        step();
        check("t1_data0", 32'(out_data[1]), 32'h11);
        check("t1_occ0", 32'(occupancy[1]), 32'd1);
        in_data[1] = 8'h22;
        step();
        check("t1_data1", 32'(out_data[1]), 32'h22);
        in_data[1] = 8'h33;
        step();
        check("t1_data2", 32'(out_data[1]), 32'h33);
        check("t1_occ2", 32'(occupancy[1]), 32'd1);
        in_valid[1] = 1'b0;
        step();
        check("t1_drain_valid", 32'(out_valid[1]), 32'd0);
        check("t1_drain_keeps", 32'(out_data[1]), 32'h33);

        // Test 2: fill the skid entry, then release
        out_ready[1] = 1'b0;
        in_valid[1]  = 1'b1;
        in_data[1]   = 8'hA1;
        step();
        in_data[1] = 8'hA2;
        step();
        in_data[1] = 8'hA3;
        check("t2_occ_full", 32'(occupancy[1]), 32'd2);
        check("t2_ready_full", 32'(in_ready[1]), 32'd0);
        step();
        check("t2_hold_data", 32'(out_data[1]), 32'hA1);
        check("t2_hold_occ", 32'(occupancy[1]), 32'd2);
        out_ready[1] = 1'b1;
        step();
        check("t2_second", 32'(out_data[1]), 32'hA2);
        check("t2_occ_one", 32'(occupancy[1]), 32'd1);
        step();
        check("t2_third", 32'(out_data[1]), 32'hA3);
        in_valid[1] = 1'b0;
        step();
        check("t2_empty", 32'(out_valid[1]), 32'd0);

        // Test 3: flush while full with a pending push
        out_ready[1] = 1'b0;
        in_valid[1]  = 1'b1;
        in_data[1]   = 8'hB1;
        step();
        in_data[1] = 8'hB2;
        step();
        flush[1]   = 1'b1;
        in_data[1] = 8'hB3;
        step();
        flush[1]    = 1'b0;
        in_valid[1] = 1'b0;
        check("t3_valid", 32'(out_valid[1]), 32'd0);
        check("t3_occ", 32'(occupancy[1]), 32'd0);
        check("t3_data", 32'(out_data[1]), 32'h00);
        check("t3_ready", 32'(in_ready[1]), 32'd1);
        out_ready[1] = 1'b1;
        step();
        step();
        check("t3_no_b3", 32'(out_valid[1]), 32'd0);

        // Test 4: asynchronous reset while full
        out_ready[1] = 1'b0;
        in_valid[1]  = 1'b1;
        in_data[1]   = 8'hC1;
        step();
        in_data[1] = 8'hC2;
        step();
        in_valid[1] = 1'b0;
        check("t4_pre_occ", 32'(occupancy[1]), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("t4_valid", 32'(out_valid[1]), 32'd0);
        check("t4_occ", 32'(occupancy[1]), 32'd0);
        check("t4_ready", 32'(in_ready[1]), 32'd1);
        check("t4_data", 32'(out_data[1]), 32'h00);
        step();
        reset = 1'b0;
        step();

        // Test 5: 1-entry variant, out_ready alternating
        d = 8'h01;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            out_ready[0] = (i % 2 == 0);
            in_data[0]   = d;
            exp_rdy      = (i % 2 == 0);
            #1;
            check($sformatf("t5_ready_%0d", i), 32'(in_ready[0]), 32'(exp_rdy));
            @(posedge clk);
            #1;
            if (exp_rdy) d = d + 8'h01;
        end
        check("t5_last_data", 32'(out_data[0]), 32'h04);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        step();
        step();

        // Test 6: random traffic on both variants, including flushes
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) fired[k] = in_valid[k] && in_ready[k];
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (!in_valid[k] || fired[k]) begin
                    in_valid[k] = ($urandom_range(0, 3) != 0);
                    in_data[k]  = 8'($urandom_range(0, 255));
                end
                out_ready[k] = ($urandom_range(0, 2) != 0);
                flush[k]     = ($urandom_range(0, 49) == 0);
            end
        end
        for (int k = 0; k < 2; k++) begin
            flush[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
